// File: rtl/alu_pkg.sv
// alu_pkg
// Shared ALU definitions: opcode encodings, the index of each flag bit inside
// the 4-bit flag vector {C,D,N,Z}, and the flag vector type.
// No ports (package).

package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_NAND = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd9;
  localparam logic [3:0] OP_MOD  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;

  // Highest opcode the ALU defines; anything above is treated as illegal.
  localparam logic [3:0] OP_LAST = OP_SHR;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_D = 2;
  localparam int FLAG_C = 3;

  localparam int FLAGS_W = 4;
  typedef logic [FLAGS_W-1:0] flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen
// Combinational clean-up of an ALU result before it is queued: illegal
// opcodes and division/modulo by zero are forced to a zero result, and the
// {C,D,N,Z} flags are derived from the cleaned result.
// Flag generation exists only when ALU_RESULT_QUEUE_FLAGS_EN is defined;
// otherwise the result passes through untouched and flags are zero.
//
// Ports:
//   result       in   RES_W  raw ALU result
//   op           in   4      opcode that produced the result
//   y_zero       in   1      y operand was zero
//   clean_result out  RES_W  result to store
//   flags        out  4      {C,D,N,Z}

module alu_flag_gen #(
  parameter int RES_W = 8
) (
  input  logic [RES_W-1:0] result,
  input  logic [3:0]       op,
  input  logic             y_zero,
  output logic [RES_W-1:0] clean_result,
  output logic [3:0]       flags
);

`ifdef ALU_RESULT_QUEUE_FLAGS_EN
  import alu_pkg::*;

  // The flags are computed from the already-cleaned result so that a forced
  // zero always reports Z=1 and N=0.
  always_comb begin
    clean_result = result;
    flags        = '0;
    if (op > OP_LAST) begin
      clean_result = '0;
    end else if ((op == OP_DIV || op == OP_MOD) && y_zero) begin
      clean_result  = '0;
      flags[FLAG_D] = 1'b1;
    end
    flags[FLAG_Z] = (clean_result == '0);
    flags[FLAG_N] = clean_result[RES_W-1];
    flags[FLAG_C] = (op == OP_ADD) && clean_result[4];
  end
`else
  // Without flag generation the opcode and zero indication have no effect.
  logic unused_ctl;
  assign unused_ctl   = ^{op, y_zero};
  assign clean_result = result;
  assign flags        = '0;
`endif

endmodule

// File: rtl/alu_result_queue.sv
// alu_result_queue
// Small FIFO that buffers ALU results (with opcode and optional flags)
// between a producer and a consumer using valid/ready handshakes on both
// sides. The head entry is presented directly from the storage registers.
// Optional feature macro: ALU_RESULT_QUEUE_FLAGS_EN (flag generation/storage).
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      producer offers a result
//   in_ready   out  1      queue not full
//   in_result  in   RES_W  ALU result
//   in_op      in   4      opcode
//   in_y_zero  in   1      y operand was zero
//   out_valid  out  1      queue not empty
//   out_ready  in   1      consumer takes head
//   out_result out  RES_W  head result
//   out_op     out  4      head opcode
//   out_flags  out  4      head flags {C,D,N,Z}
//   count      out  5      occupancy 0..DEPTH

module alu_result_queue #(
  parameter int DEPTH = 4,
  parameter int RES_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_result,
  input  logic [3:0]       in_op,
  input  logic             in_y_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic [3:0]       out_op,
  output logic [3:0]       out_flags,
  output logic [4:0]       count
);

  import alu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [RES_W-1:0] mem_result [DEPTH];
  logic [3:0]       mem_op     [DEPTH];
  logic [RES_W-1:0] clean_result;
  flags_t           gen_flags;
  logic             push;
  logic             pop;

  alu_flag_gen #(.RES_W(RES_W)) u_flag_gen (
    .result       (in_result),
    .op           (in_op),
    .y_zero       (in_y_zero),
    .clean_result (clean_result),
    .flags        (gen_flags)
  );

  // Full/empty come straight from the occupancy counter, so in_ready never
  // depends on out_ready.
  assign in_ready  = (count != 5'(DEPTH));
  assign out_valid = (count != 5'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is cleared on reset so the head outputs read zero afterwards.
  // Pointers are PTR_W bits wide and DEPTH is a power of two, so they wrap
  // naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= '0;
        mem_op[i]     <= '0;
      end
    end else begin
      if (push) begin
        mem_result[wr_ptr] <= clean_result;
        mem_op[wr_ptr]     <= in_op;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_result = mem_result[rd_ptr];
  assign out_op     = mem_op[rd_ptr];

`ifdef ALU_RESULT_QUEUE_FLAGS_EN
  flags_t mem_flags [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_flags[i] <= '0;
      end
    end else if (push) begin
      mem_flags[wr_ptr] <= gen_flags;
    end
  end

  assign out_flags = mem_flags[rd_ptr];
`else
  // No flag storage in this build; the generator's zero flags are dropped.
  flags_t unused_gen_flags;
  assign unused_gen_flags = gen_flags;
  assign out_flags        = '0;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue
// Directed and randomized stimulus for alu_result_queue. The stimulus side
// pushes the expected entry into a scoreboard queue whenever a push will be
// accepted; a separate negedge monitor compares occupancy, handshakes and
// the head entry, popping the scoreboard when the consumer takes an entry.

module tb_alu_result_queue;

  localparam int DEPTH = 4;
  localparam int RES_W = 8;

  typedef struct {
    logic [RES_W-1:0] res;
    logic [3:0]       op;
    logic [3:0]       flags;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_result;
  logic [3:0]       in_op;
  logic             in_y_zero;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic [3:0]       out_op;
  logic [3:0]       out_flags;
  logic [4:0]       count;

  exp_t exp_q[$];
  bit   pend_push = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  alu_result_queue #(.DEPTH(DEPTH), .RES_W(RES_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_op      (in_op),
    .in_y_zero  (in_y_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_flags  (out_flags),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Reference behaviour from the ALU result rules, flags packed {C,D,N,Z}.
  function automatic exp_t modelEntry(input int res, input int op, input bit yz);
    exp_t e;
    int   r;
    int   c, d, n, z;
    r = res;
    c = 0; d = 0;
`ifdef ALU_RESULT_QUEUE_FLAGS_EN
    if (op >= 13) begin
      r = 0;
    end else if ((op == 3 || op == 10) && yz) begin
      r = 0;
      d = 1;
    end
    z = (r == 0) ? 1 : 0;
    n = (r >> (RES_W - 1)) & 1;
    if (op == 0) c = (r >> 4) & 1;
    e.flags = 4'((c * 8) + (d * 4) + (n * 2) + z);
`else
    e.flags = 4'd0;
`endif
    e.res = RES_W'(r);
    e.op  = 4'(op);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge and records the
  // expected entry if the model says the queue has room.
  task automatic applyStimulus(input bit v, input int res, input int op, input bit yz, input bit ordy);
    in_valid  = v;
    in_result = RES_W'(res);
    in_op     = 4'(op);
    in_y_zero = yz;
    out_ready = ordy;
    if (v && exp_q.size() != DEPTH) begin
      exp_q.push_back(modelEntry(res, op, yz));
      pend_push = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input bit v);
    rst       = 1'b1;
    in_valid  = v;
    in_result = RES_W'(8'hF1);
    in_op     = 4'd1;
    in_y_zero = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    pend_push = 1'b0;
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_result", int'(out_result), 0);
    checkOutput("reset_out_op", int'(out_op), 0);
    checkOutput("reset_out_flags", int'(out_flags), 0);
  endtask

  // Monitor: compare against model occupancy (excluding a push that has not
  // reached the edge yet), then retire the head if the consumer takes it.
  always @(negedge clk) begin
    if (!rst) begin
      int occ;
      occ = exp_q.size() - (pend_push ? 1 : 0);
      checkOutput("count", int'(count), occ);
      checkOutput("out_valid", int'(out_valid), (occ != 0) ? 1 : 0);
      checkOutput("in_ready", int'(in_ready), (occ != DEPTH) ? 1 : 0);
      if (occ > 0) begin
        checkOutput("head_result", int'(out_result), int'(exp_q[0].res));
        checkOutput("head_op", int'(out_op), int'(exp_q[0].op));
        checkOutput("head_flags", int'(out_flags), int'(exp_q[0].flags));
        if (out_ready) void'(exp_q.pop_front());
      end
      pend_push = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    int waited;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    in_op     = '0;
    in_y_zero = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    doReset(1'b1);

    // ADD result with bit 4 set: C=1 only.
    applyStimulus(1'b1, 'h13, 0, 1'b0, 1'b0);
    checkOutput("add_valid", int'(out_valid), 1);
    checkOutput("add_result", int'(out_result), 'h13);
`ifdef ALU_RESULT_QUEUE_FLAGS_EN
    checkOutput("add_flags", int'(out_flags), 'b1000);
`else
    checkOutput("add_flags", int'(out_flags), 0);
`endif
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

    // Division by zero.
    applyStimulus(1'b1, 'hFF, 3, 1'b1, 1'b0);
`ifdef ALU_RESULT_QUEUE_FLAGS_EN
    checkOutput("div0_result", int'(out_result), 0);
    checkOutput("div0_flags", int'(out_flags), 'b0101);
`else
    checkOutput("div0_result", int'(out_result), 'hFF);
    checkOutput("div0_flags", int'(out_flags), 0);
`endif
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

    // Division by zero with a different pattern.
    applyStimulus(1'b1, 'hAA, 3, 1'b1, 1'b0);
`ifdef ALU_RESULT_QUEUE_FLAGS_EN
    checkOutput("div0b_result", int'(out_result), 0);
`else
    checkOutput("div0b_result", int'(out_result), 'hAA);
    checkOutput("div0b_flags", int'(out_flags), 0);
`endif
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

    // Fill, attempt a fifth push, then pop-only while full.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 'h20 + i, i + 4, 1'b0, 1'b0);
    checkOutput("full_count", int'(count), DEPTH);
    checkOutput("full_in_ready", int'(in_ready), 0);
    applyStimulus(1'b1, 'h77, 1, 1'b0, 1'b0);
    checkOutput("full_ignored_count", int'(count), DEPTH);
    applyStimulus(1'b1, 'h66, 2, 1'b0, 1'b1);
    checkOutput("full_pop_count", int'(count), DEPTH - 1);
    checkOutput("full_pop_in_ready", int'(in_ready), 1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("drained_count", int'(count), 0);

    // Reset overrides a push when two entries are queued.
    applyStimulus(1'b1, 'h01, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 'h02, 2, 1'b0, 1'b0);
    checkOutput("pre_reset_count", int'(count), 2);
    doReset(1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        doReset($urandom_range(0, 1) == 1);
      end else begin
        applyStimulus($urandom_range(0, 2) != 0, int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) != 0);
      end
    end

    // Drain with a bounded budget.
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      waited++;
    end
    checkOutput("final_drain_left", exp_q.size(), 0);
    checkOutput("final_count", int'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_queue.md
ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RES_W, default 8, result width, matching the ALU output.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  producer has an ALU result this cycle.
REQ-006 SHALL have port in_ready  output  1  queue accepts a result this cycle.
REQ-007 SHALL have port in_result  input  RES_W  combinational ALU result.
REQ-008 SHALL have port in_op  input  4  opcode that produced in_result (0..12 valid).
REQ-009 SHALL have port in_y_zero  input  1  y operand was zero.
REQ-010 SHALL have port out_valid  output  1  head entry available.
REQ-011 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-012 SHALL have port out_result  output  RES_W  head result.
REQ-013 SHALL have port out_op  output  4  head opcode.
REQ-014 SHALL have port out_flags  output  4  head flags {C,D,N,Z}.
REQ-015 SHALL have port count  output  5  current occupancy, 0..DEPTH.

Function
REQ-016 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL equal (count != DEPTH), independent of out_ready (no full-time pass-through).
REQ-018 out_valid SHALL equal (count != 0); out_* SHALL be registered head-entry contents, stable while out_valid && !out_ready.
REQ-019 Latency: pushed entry into empty queue SHALL appear on out_* with out_valid=1 in the next cycle.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; when count==0 only push is possible.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; ordering SHALL be strictly FIFO.
REQ-022 Div-by-zero: in_op in {3,10} with in_y_zero=1 SHALL store result 0 and set D=1.
REQ-023 Z SHALL be 1 when the stored result equals 0.
REQ-024 N SHALL be stored result bit RES_W-1.
REQ-025 C SHALL be stored result bit 4 when in_op==0, else 0.
REQ-026 in_op values 13..15 SHALL be stored with result 0 and flags {0,0,0,1}.
REQ-027 in_result SHALL be sampled only on push cycles; other cycles SHALL not affect state.

Reset
REQ-028 While rst=1 at a clock edge: count=0, pointers=0, out_valid=0, in_ready=1 next cycle.
REQ-029 After reset out_result, out_op, out_flags SHALL be 0.
REQ-030 Reset SHALL override a push/pop in the same cycle; queued entries SHALL be discarded.

Configuration
REQ-031 Macro ALU_RESULT_QUEUE_FLAGS_EN SHALL gate flag generation.
REQ-032 Defined: flags per REQ-022..REQ-026; undefined: out_flags SHALL be constant 0, no flag storage, div-by-zero results stored unmodified.

Structure
REQ-033 Shared package alu_pkg SHALL hold opcode constants (OP_ADD=0 .. OP_SHR=12) and flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_D=2, FLAG_C=3).
REQ-034 A sub-module alu_flag_gen (combinational, result/op/y_zero -> sanitised result and flags) SHALL be instantiated once.

Verification
REQ-035 Reset then push op=0 result=0x13 -> next cycle out_valid=1, out_result=0x13, out_flags={C=1,D=0,N=0,Z=0}.
REQ-036 Push op=3 in_y_zero=1 in_result=0xFF -> out_result=0x00, flags D=1,Z=1.
REQ-037 Push 4 entries with out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored; drain returns all 4 in order.
REQ-038 Full queue, in_valid=1 and out_ready=1 same cycle -> pop only, count 4->3, in_ready=1 next cycle.
REQ-039 Push op=1 result=0xF1 with count=2, assert rst same cycle -> count=0, out_valid=0 next cycle.
REQ-040 Build without ALU_RESULT_QUEUE_FLAGS_EN, push op=3 in_y_zero=1 result=0xAA -> out_result=0xAA, out_flags=0.
